rx_da_filter: RTL

RX_DA_FILTER -- requirements
Module: rx_da_filter

---
 rtl/rx_da_pkg.sv | 15 +
 rtl/crc32_byte.sv | 21 ++
 rtl/rx_da_filter.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/rx_da_pkg.sv
// Shared definitions for the receive destination-address filter.
//   CRC_POLY / CRC_INIT : reflected CRC-32 polynomial and seed for the DA hash
//   DA_BYTES            : length of a MAC destination address in bytes
//   daState_t           : capture FSM states
package rx_da_pkg;
    localparam logic [31:0] CRC_POLY = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;
    localparam int          DA_BYTES = 6;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        HOLD    = 2'd2
    } daState_t;
endpackage

// File: rtl/crc32_byte.sv
// Combinational one-byte update of a reflected CRC-32 (LSB of the byte first).
//   crc_in  : running CRC before this byte
//   byte_in : data byte
//   crc_out : running CRC after this byte
module crc32_byte
    import rx_da_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  byte_in,
    output logic [31:0] crc_out
);
    logic [31:0] c;

    always_comb begin
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            c = {1'b0, c[31:1]} ^ (CRC_POLY & {32{c[0] ^ byte_in[i]}});
        end
        crc_out = c;
    end
endmodule

// File: rtl/rx_da_filter.sv
// Receive destination-address filter: captures the 6 DA bytes at the head of
// each frame and classifies them (broadcast / multicast / own unicast) plus an
// optional CRC-32 hash index for a downstream address-select table.
//   clk, resetn    : clock and synchronous active-low reset
//   rx_sof, rx_dv  : start-of-frame marker and byte-valid qualifier
//   rx_data        : byte stream, DA byte 0 first
//   rx_abort       : frame discarded; drops an in-progress capture
//   station_addr   : own MAC, byte 0 in bits [7:0]
//   da_done        : one-cycle pulse when the result outputs below are updated
//   da_hash        : crc[HASH_W-1:0] of the DA (0 unless hashing is built in)
//   da_bcast, da_mcast, da_ucast_match : address classification
//   busy           : capture in progress
// Build option: define RX_DA_FILTER_HASH_EN to include the CRC hash logic.
module rx_da_filter
    import rx_da_pkg::*;
#(
    parameter int HASH_W = 7
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              rx_sof,
    input  logic              rx_dv,
    input  logic [7:0]        rx_data,
    input  logic              rx_abort,
    input  logic [47:0]       station_addr,
    output logic              da_done,
    output logic [HASH_W-1:0] da_hash,
    output logic              da_bcast,
    output logic              da_mcast,
    output logic              da_ucast_match,
    output logic              busy
);
    localparam logic [2:0] LAST_IDX = 3'(DA_BYTES - 1);

    daState_t   state, stateNxt;
    logic [2:0] cnt;
    logic       sofHit;
    logic       takeFirst, takeNext, takeLast;

    // Running per-byte flags; the DA itself is never stored.
    logic       bcastRun, matchRun, mcastBit;
    logic [7:0] staByte;
    logic       byteIsFf, byteMatch;

    assign sofHit = rx_dv & rx_sof;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (!resetn) state <= IDLE;
        else         state <= stateNxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        stateNxt = state;
        case (state)
            IDLE:    if (sofHit) stateNxt = CAPTURE;
            CAPTURE: begin
                if (rx_abort)      stateNxt = IDLE;    // abort beats sof
                else if (sofHit)   stateNxt = CAPTURE; // restart at byte 0
                else if (takeLast) stateNxt = HOLD;
            end
            HOLD:    if (sofHit) stateNxt = CAPTURE;
            default: stateNxt = IDLE;
        endcase
    end

    // ---------------- FSM: outputs / byte strobes ----------------
    always_comb begin
        busy      = (state == CAPTURE);
        // rx_abort only matters while capturing
        takeFirst = sofHit & ~((state == CAPTURE) & rx_abort);
        takeNext  = (state == CAPTURE) & rx_dv & ~rx_sof & ~rx_abort;
        takeLast  = takeNext & (cnt == LAST_IDX);
    end

    // Station byte to compare against the incoming byte.
    always_comb begin
        staByte = station_addr[7:0];
        if (!takeFirst) begin
            case (cnt)
                3'd1:    staByte = station_addr[15:8];
                3'd2:    staByte = station_addr[23:16];
                3'd3:    staByte = station_addr[31:24];
                3'd4:    staByte = station_addr[39:32];
                3'd5:    staByte = station_addr[47:40];
                default: staByte = station_addr[7:0];
            endcase
        end
    end

    assign byteIsFf  = (rx_data == 8'hFF);
    assign byteMatch = (rx_data == staByte);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt            <= 3'd0;
            bcastRun       <= 1'b0;
            matchRun       <= 1'b0;
            mcastBit       <= 1'b0;
            da_done        <= 1'b0;
            da_bcast       <= 1'b0;
            da_mcast       <= 1'b0;
            da_ucast_match <= 1'b0;
        end else begin
            da_done <= 1'b0;
            if (takeFirst) begin
                cnt      <= 3'd1;
                bcastRun <= byteIsFf;
                matchRun <= byteMatch;
                mcastBit <= rx_data[0];
            end else if (takeNext) begin
                cnt      <= cnt + 3'd1;
                bcastRun <= bcastRun & byteIsFf;
                matchRun <= matchRun & byteMatch;
                if (takeLast) begin
                    da_done        <= 1'b1;
                    da_bcast       <= bcastRun & byteIsFf;
                    da_mcast       <= mcastBit & ~(bcastRun & byteIsFf);
                    da_ucast_match <= matchRun & byteMatch;
                end
            end
        end
    end

`ifdef RX_DA_FILTER_HASH_EN
    logic [31:0] crc, crcSeed, crcNxt;

    // A new frame always hashes from the seed, even on a mid-capture restart.
    assign crcSeed = takeFirst ? CRC_INIT : crc;

    crc32_byte uCrc (
        .crc_in  (crcSeed),
        .byte_in (rx_data),
        .crc_out (crcNxt)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            crc     <= CRC_INIT;
            da_hash <= '0;
        end else begin
            if (takeFirst || takeNext) crc <= crcNxt;
            if (takeLast)              da_hash <= crcNxt[HASH_W-1:0];
        end
    end
`else
    assign da_hash = '0;
`endif

endmodule
